// File: rtl/video_pattern_generator.sv
// Self-timed raster source: owns its h/v counters and emits a registered RGB test pattern
// (colour bars, checkerboard, gradient, bouncing box) with position and sync aligned to it.
module video_pattern_generator #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned COLOR_BITS = 8,
   parameter int unsigned BOX_SIZE   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [1:0]            i_mode,
   output logic [9:0]            o_hpos,
   output logic [9:0]            o_vpos,
   output logic                  o_visible,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic                  o_frame_start,
   output logic [COLOR_BITS-1:0] o_r,
   output logic [COLOR_BITS-1:0] o_g,
   output logic [COLOR_BITS-1:0] o_b
);
   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned X_MAX        = H_VISIBLE - BOX_SIZE;
   localparam int unsigned Y_MAX        = V_VISIBLE - BOX_SIZE;
   localparam int unsigned CW           = COLOR_BITS;

   logic [9:0] hcnt, vcnt;
   logic [1:0] mode_q;
   logic [7:0] frame_q;
   logic       first_q;
   logic [9:0] box_x_q, box_y_q;
   logic       box_dx_neg_q, box_dy_neg_q;

   logic       origin_c;
   logic [1:0] mode_c;
   logic [7:0] frame_c;
   logic [9:0] box_x_c, box_y_c;
   logic       box_dx_neg_c, box_dy_neg_c;

   logic          visible_c, hsync_c, vsync_c, checker_c, in_box_c;
   logic [2:0]    bar_c;
   logic [CW-1:0] r_c, g_c, b_c;

   // One-axis unit-speed bounce: returns {moving_negative, new_position}
   function automatic logic [10:0] bounce(input logic [9:0] pos, input logic neg,
                                          input logic [9:0] max_pos);
      logic [10:0] res;
      if (!neg) begin
         if (pos >= max_pos) res = {1'b1, pos - 10'd1};
         else                res = {1'b0, pos + 10'd1};
      end else begin
         if (pos == 10'd0)   res = {1'b0, 10'd1};
         else                res = {1'b1, pos - 10'd1};
      end
      return res;
   endfunction

   // Frame-level state seen by every pixel of the frame, including pixel (0,0)
   always_comb begin
      origin_c     = (hcnt == 10'd0) && (vcnt == 10'd0);
      mode_c       = mode_q;
      frame_c      = frame_q;
      box_x_c      = box_x_q;
      box_y_c      = box_y_q;
      box_dx_neg_c = box_dx_neg_q;
      box_dy_neg_c = box_dy_neg_q;
      if (origin_c) begin
         mode_c = i_mode;
         if (!first_q) frame_c = frame_q + 8'd1;
         if (i_mode == 2'd3) begin
            {box_dx_neg_c, box_x_c} = bounce(box_x_q, box_dx_neg_q, 10'(X_MAX));
            {box_dy_neg_c, box_y_c} = bounce(box_y_q, box_dy_neg_q, 10'(Y_MAX));
         end
      end
   end

   // Pixel colour and sync for the current counter state
   always_comb begin
      visible_c = (hcnt < 10'(H_VISIBLE)) && (vcnt < 10'(V_VISIBLE));
      hsync_c   = !((hcnt >= 10'(H_SYNC_START)) && (hcnt < 10'(H_SYNC_END)));
      vsync_c   = !((vcnt >= 10'(V_SYNC_START)) && (vcnt < 10'(V_SYNC_END)));
      bar_c     = 3'd0;
      for (int unsigned k = 1; k < 8; k++) begin
         if ({hcnt, 3'b000} >= 13'(k * H_VISIBLE)) bar_c = 3'(k);
      end
      checker_c = hcnt[5] ^ vcnt[5];
      in_box_c  = ({1'b0, hcnt} >= {1'b0, box_x_c}) &&
                  ({1'b0, hcnt} <  11'(box_x_c) + 11'(BOX_SIZE)) &&
                  ({1'b0, vcnt} >= {1'b0, box_y_c}) &&
                  ({1'b0, vcnt} <  11'(box_y_c) + 11'(BOX_SIZE));
      r_c = '0;
      g_c = '0;
      b_c = '0;
      case (mode_c)
         2'd0: begin
            r_c = {CW{~bar_c[1]}};
            g_c = {CW{~bar_c[2]}};
            b_c = {CW{~bar_c[0]}};
         end
         2'd1: begin
            r_c = {CW{checker_c}};
            g_c = {CW{checker_c}};
            b_c = {CW{checker_c}};
         end
         2'd2: begin
            r_c = hcnt[CW-1:0];
            g_c = vcnt[CW-1:0];
            b_c = CW'({frame_c, 10'd0} >> (18 - CW));
         end
         default: begin
            r_c = {CW{in_box_c}};
            g_c = {CW{in_box_c}};
            b_c = '1;
         end
      endcase
      if (!visible_c) begin
         r_c = '0;
         g_c = '0;
         b_c = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hcnt          <= '0;
         vcnt          <= '0;
         mode_q        <= '0;
         frame_q       <= '0;
         first_q       <= 1'b1;
         box_x_q       <= '0;
         box_y_q       <= '0;
         box_dx_neg_q  <= 1'b0;
         box_dy_neg_q  <= 1'b0;
         o_hpos        <= '0;
         o_vpos        <= '0;
         o_visible     <= 1'b0;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         o_frame_start <= 1'b0;
         o_r           <= '0;
         o_g           <= '0;
         o_b           <= '0;
      end else begin
         if (hcnt == 10'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
         if (origin_c) first_q <= 1'b0;
         mode_q        <= mode_c;
         frame_q       <= frame_c;
         box_x_q       <= box_x_c;
         box_y_q       <= box_y_c;
         box_dx_neg_q  <= box_dx_neg_c;
         box_dy_neg_q  <= box_dy_neg_c;
         o_hpos        <= hcnt;
         o_vpos        <= vcnt;
         o_visible     <= visible_c;
         o_hsync       <= hsync_c;
         o_vsync       <= vsync_c;
         o_frame_start <= origin_c;
         o_r           <= r_c;
         o_g           <= g_c;
         o_b           <= b_c;
      end
   end
endmodule
